// File: rtl/lfsr_cipher_pkg.sv
// rtl/lfsr_cipher_pkg.sv - shared state, width and key types for the cipher sequencer
package lfsr_cipher_pkg;
    localparam int PIXEL_W = 24;
    localparam int KEY_W   = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WARM   = 3'd1,
        FETCH  = 3'd2,
        RDWAIT = 3'd3,
        EMIT   = 3'd4,
        DONE   = 3'd5
    } state_e;

    typedef struct packed {
        logic [KEY_W-1:0] r;
        logic [KEY_W-1:0] g;
        logic [KEY_W-1:0] b;
    } key_t;
endpackage

// File: rtl/key_fifo2.sv
// rtl/key_fifo2.sv - two-entry key triplet FIFO with flush; push while full is accepted only alongside a pop
module key_fifo2
    import lfsr_cipher_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_flush,
    input  logic       i_push,
    input  key_t       i_data,
    input  logic       i_pop,
    output key_t       o_head,
    output logic [1:0] o_count,
    output logic       o_full,
    output logic       o_empty
);
    key_t       r_mem [2];
    logic       r_rd_ptr;
    logic       r_wr_ptr;
    logic [1:0] r_count;
    logic       w_push;
    logic       w_pop;

    assign w_pop  = i_pop && (r_count != 2'd0);
    assign w_push = i_push && ((r_count != 2'd2) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            // When full, write and read pointers coincide: the slot being popped is the one refilled.
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == 2'd2);
    assign o_empty = (r_count == 2'd0);
endmodule

// File: rtl/lfsr_cipher_sequencer.sv
// rtl/lfsr_cipher_sequencer.sv - one image pass: discard warm-up keys, fetch pixels, XOR with buffered keys, stream out
module lfsr_cipher_sequencer
    import lfsr_cipher_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int NUM_PIXELS = 4096,
    parameter int WARMUP     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               key_en,
    input  logic               key_ready,
    input  logic [KEY_W-1:0]   r_key,
    input  logic [KEY_W-1:0]   g_key,
    input  logic [KEY_W-1:0]   b_key,
    output logic               pix_rd_en,
    output logic [ADDR_W-1:0]  pix_addr,
    input  logic [PIXEL_W-1:0] pix_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_addr,
    output logic [PIXEL_W-1:0] out_pix,
    output logic               key_ovf
);
    localparam int WARM_W = (WARMUP < 2) ? 1 : $clog2(WARMUP + 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [ADDR_W-1:0]  r_idx;
    logic [WARM_W-1:0]  r_warm;
    logic [PIXEL_W-1:0] r_pix;
    logic               r_key_en;
    logic               r_key_ovf;
    key_t               w_head;
    key_t               w_key_in;
    logic [1:0]         w_count;
    logic [1:0]         w_count_nxt;
    logic               w_full;
    logic               w_empty;
    logic               w_stream;
    logic               w_valid;
    logic               w_hs;
    logic               w_last;
    logic               w_start;
    logic               w_flush;
    logic               w_push;
    logic               w_drop;
    logic               w_busy_nxt;

    assign w_key_in    = {r_key, g_key, b_key};
    assign w_stream    = (r_state == FETCH) || (r_state == RDWAIT) || (r_state == EMIT);
    assign w_valid     = (r_state == EMIT) && !w_empty;
    assign w_hs        = w_valid && out_ready;
    assign w_last      = (r_idx == ADDR_W'(NUM_PIXELS - 1));
    assign w_start     = (r_state == IDLE) && start;
    assign w_flush     = (r_state == DONE);
    assign w_push      = key_ready && w_stream && (!w_full || w_hs);
    assign w_drop      = key_ready && w_stream && w_full && !w_hs;
    assign w_count_nxt = w_flush ? 2'd0 : (w_count + {1'b0, w_push} - {1'b0, w_hs});

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = (WARMUP > 0) ? WARM : FETCH;
            WARM:    if (key_ready && (r_warm == WARM_W'(1))) w_state_nxt = FETCH;
            FETCH:   w_state_nxt = RDWAIT;
            RDWAIT:  w_state_nxt = EMIT;
            EMIT:    if (w_hs) w_state_nxt = w_last ? DONE : FETCH;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_busy_nxt = w_state_nxt inside {WARM, FETCH, RDWAIT, EMIT};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_warm    <= '0;
            r_pix     <= '0;
            r_key_en  <= 1'b0;
            r_key_ovf <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Warm-up keys are never stored, so WARM always asks the generator for more.
            r_key_en <= w_busy_nxt && ((w_state_nxt == WARM) || (w_count_nxt != 2'd2));
            if (w_start) begin
                r_warm    <= WARM_W'(WARMUP);
                r_idx     <= '0;
                r_key_ovf <= 1'b0;
            end else if ((r_state == WARM) && key_ready) begin
                r_warm <= r_warm - WARM_W'(1);
            end
            if (r_state == RDWAIT) begin
                r_pix <= pix_rdata;
            end
            if (w_hs && !w_last) begin
                r_idx <= r_idx + ADDR_W'(1);
            end
            if (w_flush) begin
                r_idx <= '0;
            end
            if (w_drop) begin
                r_key_ovf <= 1'b1;
            end
        end
    end

    key_fifo2 u_key_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_flush),
        .i_push  (w_push),
        .i_data  (w_key_in),
        .i_pop   (w_hs),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign busy      = r_state inside {WARM, FETCH, RDWAIT, EMIT};
    assign done      = (r_state == DONE);
    assign key_en    = r_key_en;
    assign pix_rd_en = (r_state == FETCH);
    assign pix_addr  = r_idx;
    assign out_valid = w_valid;
    assign out_addr  = r_idx;
    assign out_pix   = w_valid ? (r_pix ^ w_head) : '0;
    assign key_ovf   = r_key_ovf;
endmodule

// File: tb/tb_lfsr_cipher_sequencer.sv
// tb/tb_lfsr_cipher_sequencer.sv - randomized self-checking bench with a key-list/pixel reference model
module tb_lfsr_cipher_sequencer;
    localparam int WU = 2;
    localparam int NP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic        key_ready = 1'b0;
    logic [7:0]  r_key = 8'h0;
    logic [7:0]  g_key = 8'h0;
    logic [7:0]  b_key = 8'h0;
    logic        out_ready = 1'b0;

    logic        busy_a, done_a, key_en_a, pix_rd_en_a, out_valid_a, key_ovf_a;
    logic [11:0] pix_addr_a, out_addr_a;
    logic [23:0] pix_rdata_a = 24'h0;
    logic [23:0] out_pix_a;
    logic        busy_b, done_b, key_en_b, pix_rd_en_b, out_valid_b, key_ovf_b;
    logic [11:0] pix_addr_b, out_addr_b;
    logic [23:0] pix_rdata_b = 24'h0;
    logic [23:0] out_pix_b;
    logic [53:0] vec_a, vec_b;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_hs, n_done, stall_left;
    logic [23:0] key_q[$];
    bit          prev_last, aborted;
    bit          g_raw_key = 0, g_fixed_key = 0, g_spam = 0;
    int          g_key_pct = 100, g_rdy_pct = 100, g_stall_at = -1, g_rst_at = -1;

    always #5 clk = ~clk;

    lfsr_cipher_sequencer #(.ADDR_W(12), .NUM_PIXELS(NP), .WARMUP(WU)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a), .key_en(key_en_a),
        .key_ready(key_ready), .r_key(r_key), .g_key(g_key), .b_key(b_key),
        .pix_rd_en(pix_rd_en_a), .pix_addr(pix_addr_a), .pix_rdata(pix_rdata_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_addr(out_addr_a), .out_pix(out_pix_a),
        .key_ovf(key_ovf_a)
    );

    lfsr_cipher_sequencer #(.ADDR_W(12), .NUM_PIXELS(1), .WARMUP(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b), .key_en(key_en_b),
        .key_ready(key_ready), .r_key(r_key), .g_key(g_key), .b_key(b_key),
        .pix_rd_en(pix_rd_en_b), .pix_addr(pix_addr_b), .pix_rdata(pix_rdata_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_addr(out_addr_b), .out_pix(out_pix_b),
        .key_ovf(key_ovf_b)
    );

    assign vec_a = {busy_a, done_a, key_en_a, pix_rd_en_a, out_valid_a, key_ovf_a, pix_addr_a, out_addr_a, out_pix_a};
    assign vec_b = {busy_b, done_b, key_en_b, pix_rd_en_b, out_valid_b, key_ovf_b, pix_addr_b, out_addr_b, out_pix_b};

    function automatic logic [23:0] pix_of(input int a);
        return 24'h102030 + 24'(a);
    endfunction

    // Pixel memories: data valid one cycle after the read strobe.
    always @(posedge clk) begin
        if (pix_rd_en_a) pix_rdata_a <= pix_of(int'(pix_addr_a));
        if (pix_rd_en_b) pix_rdata_b <= pix_of(int'(pix_addr_b));
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; key_ready = 1'b0; out_ready = 1'b0;
        #1;
        chk(tag, {10'd0, vec_a}, 64'd0);
        #1;
        rst = 1'b0;
    endtask

    // One cycle on DUT A: drive inputs at the falling edge, then score what the next rising edge will consume.
    task automatic step_a(input bit force_start);
        logic [23:0] k;
        @(negedge clk);
        if (prev_last) chk("done_after_last", done_a, 1);
        prev_last = 0;
        if (done_a) begin
            n_done++;
            chk("busy_in_done", busy_a, 0);
        end
        if (out_valid_a && n_hs == g_rst_at) begin
            chk("rst_at_idx", out_addr_a, 2);
            rst = 1'b1; key_ready = 1'b0; out_ready = 1'b0; start_a = 1'b0;
            #1;
            chk("async_rst_outputs", {10'd0, vec_a}, 64'd0);
            #1;
            rst = 1'b0;
            aborted = 1;
            return;
        end
        start_a = force_start || (g_spam && (done_a || $urandom_range(99) < 20));
        k = g_fixed_key ? 24'hAA550F : 24'($urandom);
        {r_key, g_key, b_key} = k;
        key_ready = (g_raw_key || key_en_a) && ($urandom_range(99) < g_key_pct);
        out_ready = ($urandom_range(99) < g_rdy_pct);
        if (out_valid_a && n_hs == g_stall_at && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end
        if (key_ready && key_en_a) key_q.push_back(k);
        if (out_valid_a) begin
            chk("out_addr", out_addr_a, n_hs);
            if (key_q.size() > WU + n_hs) chk("out_pix", out_pix_a, pix_of(n_hs) ^ key_q[WU + n_hs]);
            else chk("key_missing", key_q.size(), WU + n_hs + 1);
            if (out_ready) begin
                n_hs++;
                prev_last = (n_hs == NP);
            end
        end
    endtask

    task automatic run_pass_a();
        int guard;
        n_hs = 0; n_done = 0; prev_last = 0; aborted = 0; stall_left = 5;
        key_q.delete();
        step_a(1);
        guard = 0;
        while (n_done == 0 && !aborted && guard < 500) begin
            step_a(0);
            guard++;
        end
        if (aborted) return;
        chk("pass_done_seen", n_done, 1);
        chk("pass_handshakes", n_hs, NP);
        g_spam = 0;
        for (int i = 0; i < 3; i++) begin
            step_a(0);
            chk("idle_after_done", {busy_a, out_valid_a}, 0);
        end
        chk("done_pulses", n_done, 1);
    endtask

    initial begin
        logic [23:0] kb;
        repeat (2) @(negedge clk);
        chk("reset_a", {10'd0, vec_a}, 64'd0);
        chk("reset_b", {10'd0, vec_b}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_a", {10'd0, vec_a}, 64'd0);

        // Fixed keys, everything ready: first pixel 102030 ^ AA550F.
        g_fixed_key = 1; g_key_pct = 100; g_rdy_pct = 100;
        run_pass_a();

        // Sink stalls 5 cycles on pixel 1.
        g_fixed_key = 0; g_key_pct = 60; g_rdy_pct = 100; g_stall_at = 1;
        run_pass_a();
        g_stall_at = -1;

        // start pulsed while busy and in the DONE cycle.
        g_spam = 1; g_key_pct = 70; g_rdy_pct = 70;
        run_pass_a();

        for (int p = 0; p < 6; p++) begin
            g_key_pct = $urandom_range(30, 100);
            g_rdy_pct = $urandom_range(30, 100);
            run_pass_a();
        end

        // Generator ignores key_en while the sink is stalled.
        @(negedge clk);
        start_a = 1'b1; key_ready = 1'b0; out_ready = 1'b0;
        for (int s = 1; s <= 7; s++) begin
            @(negedge clk);
            start_a = 1'b0; key_ready = 1'b1; out_ready = 1'b0;
            {r_key, g_key, b_key} = 24'hAA550F;
            if (s == 4) chk("key_en_before_full", key_en_a, 1);
            if (s == 5) begin
                chk("key_en_after_full", key_en_a, 0);
                chk("ovf_not_yet", key_ovf_a, 0);
                chk("full_out_pix", {out_valid_a, out_pix_a}, {1'b1, 24'hBA753F});
            end
            if (s >= 6) chk("key_ovf_sticky", key_ovf_a, 1);
        end
        do_reset("rst_clears_ovf");

        // Asynchronous reset mid-pass, then a clean pass from address 0 with warm-up.
        g_key_pct = 80; g_rdy_pct = 80; g_rst_at = 2;
        run_pass_a();
        chk("rst_abort_hit", aborted, 1);
        g_rst_at = -1;
        run_pass_a();

        // WARMUP=0, single pixel latency on DUT B.
        kb = 24'($urandom);
        @(negedge clk);
        start_b = 1'b1; key_ready = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        start_b = 1'b0;
        chk("b_rd_en_t1", {pix_rd_en_b, pix_addr_b, key_en_b, busy_b}, {1'b1, 12'd0, 1'b1, 1'b1});
        key_ready = 1'b1; {r_key, g_key, b_key} = kb;
        @(negedge clk);
        key_ready = 1'b0;
        chk("b_t2", {pix_rd_en_b, out_valid_b}, 0);
        @(negedge clk);
        chk("b_valid_t3", {out_valid_b, out_addr_b, out_pix_b}, {1'b1, 12'd0, pix_of(0) ^ kb});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("b_done_t4", {done_b, busy_b, out_valid_b}, 3'b100);
        @(negedge clk);
        chk("b_idle_t5", {done_b, busy_b}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
